// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the dbus arbiter: request/response structs, FSM states, requester indices.
package dbus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_DRAIN
  } arb_state_t;

  localparam int unsigned REQ_MEM   = 0;
  localparam int unsigned REQ_FETCH = 1;
  localparam int unsigned REQ_PTW   = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  // Grant index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundles the upstream request/response vectors and the downstream port of the dbus arbiter.
interface dbus_arbiter_if #(
    parameter int unsigned NREQ = 3
);
  import dbus_arbiter_pkg::*;

  dbus_req_t  [NREQ-1:0] ireq;
  dbus_resp_t [NREQ-1:0] iresp;
  dbus_req_t             oreq;
  dbus_resp_t            oresp;

  // master: requesters plus downstream responder; slave: the arbiter itself.
  modport master (output ireq, oresp, input iresp, oreq);
  modport slave (input ireq, oresp, output iresp, oreq);

endinterface

// File: rtl/dbus_arbiter_pick.sv
// Combinational picker: first valid requester found searching upward (with wrap) from start.
module dbus_arbiter_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDXW-1:0] start,
    output logic [NREQ-1:0] winner,
    output logic [IDXW-1:0] idx,
    output logic            any
);

  always_comb begin
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!any && valid[i] && (i == (32'(start) + off) % NREQ)) begin
          any       = 1'b1;
          winner[i] = 1'b1;
          idx       = IDXW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Locks one dbus port to a single requester until data_ok. Fixed priority by default;
// define DBUS_ARB_RR_EN for round-robin arbitration.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDXW = idx_width(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    dbus_arbiter_if.slave     bus,
    output logic              busy,
    output logic [IDXW-1:0]   grant_idx
);

  arb_state_t             state_q, state_d;
  logic       [IDXW-1:0]  grant_q, grant_d;
  dbus_req_t              latch_q, latch_d;
  dbus_req_t              oreq;
  dbus_resp_t [NREQ-1:0]  iresp;
  logic       [NREQ-1:0]  req_valid;
  logic       [NREQ-1:0]  resp_ok;
  logic       [NREQ-1:0]  pick_onehot;
  logic       [IDXW-1:0]  pick_idx;
  logic       [IDXW-1:0]  pick_start;
  logic                   pick_any;
  logic                   done;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_valid[i] = bus.ireq[i].valid;
    end
  end

`ifdef DBUS_ARB_RR_EN
  logic [IDXW-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (done) begin
      ptr_q <= IDXW'((32'(grant_q) + 1) % NREQ);
    end
  end

  assign pick_start = ptr_q;
`else
  assign pick_start = '0;
`endif

  dbus_arbiter_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .valid  (req_valid),
    .start  (pick_start),
    .winner (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    latch_d = latch_q;
    oreq    = '0;
    iresp   = '0;
    done    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_GRANT;
          grant_d = pick_idx;
        end
      end
      ARB_GRANT: begin
        oreq           = bus.ireq[grant_q];
        iresp[grant_q] = bus.oresp;
        if (bus.ireq[grant_q].valid) begin
          latch_d = bus.ireq[grant_q];
        end
        // data_ok wins over a simultaneous withdraw so the response is still delivered.
        if (bus.oresp.data_ok) begin
          state_d = ARB_IDLE;
          done    = 1'b1;
        end else if (!bus.ireq[grant_q].valid) begin
          state_d = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        oreq = latch_q;
        if (bus.oresp.data_ok) begin
          state_d = ARB_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      latch_q <= latch_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      resp_ok[i] = iresp[i].data_ok;
    end
  end

  assign bus.oreq  = oreq;
  assign bus.iresp = iresp;
  assign busy      = (state_q != ARB_IDLE);
  assign grant_idx = (state_q == ARB_IDLE) ? '0 : grant_q;

  a_oreq_not_idle: assert property (@(posedge clk) disable iff (reset)
      oreq.valid |-> (state_q != ARB_IDLE));
  a_one_data_ok: assert property (@(posedge clk) disable iff (reset) $onehot0(resp_ok));
  a_pick_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(pick_onehot));

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed self-checking bench for dbus_arbiter (fixed priority or DBUS_ARB_RR_EN build).
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] grant_idx;
  int         tests = 0;
  int         fails = 0;

  dbus_arbiter_if #(.NREQ(3)) bus ();

  dbus_arbiter #(
    .NREQ (3),
    .IDXW (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  localparam dbus_resp_t RESP_ZERO = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 3; i++) bus.ireq[i] = '0;
    bus.oresp = '0;
  endtask

  task automatic chk_iresp_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.iresp[i] !== RESP_ZERO) begin
        fails++;
        $display("FAIL %s[%0d]: got %h expected 0", name, i, bus.iresp[i]);
      end
    end
  endtask

  task automatic test_reset();
    dbus_req_t zreq;
    zreq  = '0;
    reset = 1'b1;
    clear_all();
    step();
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests++;
    if (grant_idx !== 2'd0) begin
      fails++; $display("FAIL reset_grant: got %0d expected 0", grant_idx);
    end
    tests++;
    if (bus.oreq !== zreq) begin
      fails++; $display("FAIL reset_oreq: got %h expected 0", bus.oreq);
    end
    chk_iresp_zero("reset_iresp");
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    dbus_req_t r;
    r = '{valid: 1'b1, addr: 32'h8000_0010, size: 2'd2, strobe: 4'hF, data: 32'h1234_5678};
    bus.ireq[0] = r;
    #1;
    tests++;
    if (bus.oreq.valid !== 1'b0) begin
      fails++; $display("FAIL t1_same_cycle: got oreq.valid %b expected 0", bus.oreq.valid);
    end
    step();
    tests++;
    if (bus.oreq !== r) begin
      fails++; $display("FAIL t1_oreq: got %h expected %h", bus.oreq, r);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL t1_busy1: got %b expected 1", busy);
    end
    step();
    step();
    bus.oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hCAFE_0001};
    #1;
    tests++;
    if (bus.iresp[0] !== bus.oresp) begin
      fails++; $display("FAIL t1_iresp0: got %h expected %h", bus.iresp[0], bus.oresp);
    end
    tests++;
    if (bus.iresp[1] !== RESP_ZERO || bus.iresp[2] !== RESP_ZERO) begin
      fails++; $display("FAIL t1_iresp_other: got %h %h expected 0", bus.iresp[1], bus.iresp[2]);
    end
    step();
    clear_all();
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL t1_busy0: got %b expected 0", busy);
    end
    step();
  endtask

  task automatic test_contention();
    bus.ireq[0] = '{valid: 1'b1, addr: 32'h0000_1000, size: 2'd2, strobe: 4'h0, data: 32'h0};
    bus.ireq[1] = '{valid: 1'b1, addr: 32'h0000_2000, size: 2'd2, strobe: 4'h0, data: 32'h0};
    step();
    tests++;
    if (grant_idx !== 2'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL t2_first: got grant %0d busy %b expected 0 1", grant_idx, busy);
    end
    bus.oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0000_00AA};
    #1;
    tests++;
    if (bus.iresp[0].data_ok !== 1'b1 || bus.iresp[1] !== RESP_ZERO) begin
      fails++;
      $display("FAIL t2_resp: got ok0 %b iresp1 %h expected 1 0", bus.iresp[0].data_ok,
               bus.iresp[1]);
    end
    step();
    bus.ireq[0] = '0;
    bus.oresp   = '0;
    #1;
    tests++;
    if (busy !== 1'b0 || bus.iresp[1] !== RESP_ZERO) begin
      fails++; $display("FAIL t2_gap: got busy %b iresp1 %h expected 0 0", busy, bus.iresp[1]);
    end
    step();
    tests++;
    if (grant_idx !== 2'd1 || bus.oreq.addr !== 32'h0000_2000) begin
      fails++;
      $display("FAIL t2_second: got grant %0d addr %h expected 1 00002000", grant_idx,
               bus.oreq.addr);
    end
    bus.oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0000_00BB};
    step();
    clear_all();
    step();
  endtask

  task automatic test_withdraw();
    bus.ireq[1] = '{valid: 1'b1, addr: 32'h0000_3000, size: 2'd2, strobe: 4'h0, data: 32'h0};
    step();
    step();
    bus.ireq[1] = '{valid: 1'b0, addr: 32'hFFFF_FFFF, size: 2'd0, strobe: 4'h0, data: 32'h0};
    step();
    tests++;
    if (busy !== 1'b1 || bus.oreq.valid !== 1'b1 || bus.oreq.addr !== 32'h0000_3000) begin
      fails++;
      $display("FAIL t3_drain_oreq: got busy %b valid %b addr %h expected 1 1 00003000", busy,
               bus.oreq.valid, bus.oreq.addr);
    end
    bus.oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0000_DEAD};
    #1;
    chk_iresp_zero("t3_discard");
    step();
    bus.oresp = '0;
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL t3_idle: got busy %b expected 0", busy);
    end
    clear_all();
    step();
  endtask

  task automatic test_simultaneous();
    bus.ireq[0] = '{valid: 1'b1, addr: 32'h0000_4000, size: 2'd2, strobe: 4'h0, data: 32'h0};
    step();
    step();
    bus.ireq[0].valid = 1'b0;
    bus.oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0000_0044};
    #1;
    tests++;
    if (bus.iresp[0].data_ok !== 1'b1 || bus.iresp[0].data !== 32'h0000_0044) begin
      fails++; $display("FAIL t4_resp: got %h expected data_ok with 00000044", bus.iresp[0]);
    end
    step();
    bus.oresp = '0;
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL t4_no_drain: got busy %b expected 0", busy);
    end
    clear_all();
    step();
  endtask

  task automatic test_reset_mid_grant();
    dbus_req_t zreq;
    zreq = '0;
    bus.ireq[2] = '{valid: 1'b1, addr: 32'h0000_5000, size: 2'd2, strobe: 4'h0, data: 32'h0};
    step();
    tests++;
    if (grant_idx !== 2'd2) begin
      fails++; $display("FAIL t6_grant: got %0d expected 2", grant_idx);
    end
    reset     = 1'b1;
    bus.oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0000_0066};
    step();
    tests++;
    if (bus.oreq !== zreq || grant_idx !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL t6_after: got oreq %h grant %0d busy %b expected 0 0 0", bus.oreq,
               grant_idx, busy);
    end
    chk_iresp_zero("t6_iresp");
    reset = 1'b0;
    clear_all();
    step();
  endtask

`ifdef DBUS_ARB_RR_EN
  task automatic test_round_robin();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ireq[i] = '{valid: 1'b1, addr: 32'h100 * (i + 1), size: 2'd2, strobe: 4'h0,
                      data: 32'h0};
    end
    for (int k = 0; k < 6; k++) begin
      step();
      tests++;
      if (grant_idx !== 2'(k % 3) || busy !== 1'b1) begin
        fails++;
        $display("FAIL t5_rr[%0d]: got grant %0d busy %b expected %0d 1", k, grant_idx, busy,
                 k % 3);
      end
      bus.oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
      step();
      bus.oresp = '0;
    end
    clear_all();
    step();
  endtask
`else
  task automatic test_priority();
    bus.ireq[1] = '{valid: 1'b1, addr: 32'h0000_6100, size: 2'd2, strobe: 4'h0, data: 32'h0};
    bus.ireq[2] = '{valid: 1'b1, addr: 32'h0000_6200, size: 2'd2, strobe: 4'h0, data: 32'h0};
    step();
    tests++;
    if (grant_idx !== 2'd1) begin
      fails++; $display("FAIL prio_110: got %0d expected 1", grant_idx);
    end
    bus.oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
    step();
    bus.oresp   = '0;
    bus.ireq[0] = '{valid: 1'b1, addr: 32'h0000_6000, size: 2'd2, strobe: 4'h0, data: 32'h0};
    step();
    tests++;
    if (grant_idx !== 2'd0) begin
      fails++; $display("FAIL prio_111: got %0d expected 0", grant_idx);
    end
    bus.oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
    step();
    clear_all();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_withdraw();
    test_simultaneous();
    test_reset_mid_grant();
`ifdef DBUS_ARB_RR_EN
    test_round_robin();
`else
    test_priority();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
